// File: rtl/hex_step_counter.sv
// rtl/hex_step_counter.sv - prescaled up/down 0..MAX counter with synchronised start/stop/load controls
module hex_step_counter #(
  parameter int DIV = 50000000,
  parameter int MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       load,
  input  logic       up,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       running,
  output logic       tick,
  output logic       wrap
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [3:0]    MAXV = 4'(MAX);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [2:0]    start_s, stop_s, load_s;
  logic [1:0]    up_s;
  logic [0:0]    state;
  logic [PW-1:0] presc;

  logic start_e, stop_e, load_e, step;
  logic [3:0] q_step, d_clamp;
  logic       step_wraps;

  // Edge pulses come from the synchronised level and its one-cycle-older copy.
  assign start_e = start_s[1] & ~start_s[2];
  assign stop_e  = stop_s[1]  & ~stop_s[2];
  assign load_e  = load_s[1]  & ~load_s[2];

  assign step    = (state == RUN) && (presc == LAST);
  assign d_clamp = (d > MAXV) ? MAXV : d;

  always_comb begin
    q_step     = q;
    step_wraps = 1'b0;
    if (up_s[1]) begin
      if (q == MAXV) begin
        q_step     = 4'd0;
        step_wraps = 1'b1;
      end else begin
        q_step = q + 4'd1;
      end
    end else begin
      if (q == 4'd0) begin
        q_step     = MAXV;
        step_wraps = 1'b1;
      end else begin
        q_step = q - 4'd1;
      end
    end
  end

  assign running = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_s <= '0;
      stop_s  <= '0;
      load_s  <= '0;
      up_s    <= '0;
      state   <= IDLE;
      presc   <= '0;
      q       <= '0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      start_s <= {start_s[1:0], start};
      stop_s  <= {stop_s[1:0],  stop};
      load_s  <= {load_s[1:0],  load};
      up_s    <= {up_s[0],      up};
      tick    <= 1'b0;
      wrap    <= 1'b0;

      // A load outranks a coincident step and restarts the prescaler period.
      if (load_e) begin
        q     <= d_clamp;
        presc <= '0;
      end else if (step) begin
        q     <= q_step;
        presc <= '0;
        tick  <= 1'b1;
        wrap  <= step_wraps;
      end else if (state == RUN) begin
        presc <= presc + PW'(1);
      end

      // Stop beats a same-cycle start; leaving RUN always parks the prescaler at zero.
      if (stop_e) begin
        state <= IDLE;
        presc <= '0;
      end else if (start_e && state == IDLE) begin
        state <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_hex_step_counter.sv
// tb/tb_hex_step_counter.sv - self-checking bench for hex_step_counter (MAX=15 and MAX=9 instances)
module tb_hex_step_counter;

  localparam int DIV = 4;
  localparam int MAXS [2] = '{15, 9};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, stop = 1'b0, load = 1'b0, up = 1'b1;
  logic [3:0] d = 4'd0;

  logic [3:0] q15, q9;
  logic running15, tick15, wrap15;
  logic running9, tick9, wrap9;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: sampled-input history, run flag, cycles into current period, counts.
  logic [3:0] h_start, h_stop, h_load, h_up;
  bit  mrun;
  int  phase;
  int  mq [2];
  bit  mtick [2];
  bit  mwrap [2];

  always #5 clk = ~clk;

  hex_step_counter #(.DIV(DIV), .MAX(15)) dut15 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .load(load), .up(up), .d(d),
    .q(q15), .running(running15), .tick(tick15), .wrap(wrap15)
  );

  hex_step_counter #(.DIV(DIV), .MAX(9)) dut9 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .load(load), .up(up), .d(d),
    .q(q9), .running(running9), .tick(tick9), .wrap(wrap9)
  );

  task automatic model_reset();
    h_start = '0; h_stop = '0; h_load = '0; h_up = '0;
    mrun = 0; phase = 0;
    for (int i = 0; i < 2; i++) begin
      mq[i] = 0; mtick[i] = 0; mwrap[i] = 0;
    end
  endtask

  // An input high at sample n-2 and low at n-3 acts at the current edge n.
  task automatic model_step();
    bit se, pe, le, dir_up, do_step;
    h_start = {h_start[2:0], start};
    h_stop  = {h_stop[2:0],  stop};
    h_load  = {h_load[2:0],  load};
    h_up    = {h_up[2:0],    up};
    se = h_start[2] && !h_start[3];
    pe = h_stop[2]  && !h_stop[3];
    le = h_load[2]  && !h_load[3];
    dir_up  = h_up[2];
    do_step = mrun && (phase == DIV - 1);
    for (int i = 0; i < 2; i++) begin
      mtick[i] = 0; mwrap[i] = 0;
      if (le) begin
        mq[i] = (int'(d) > MAXS[i]) ? MAXS[i] : int'(d);
      end else if (do_step) begin
        mtick[i] = 1;
        if (dir_up) begin
          mwrap[i] = (mq[i] == MAXS[i]);
          mq[i] = (mq[i] + 1) % (MAXS[i] + 1);
        end else begin
          mwrap[i] = (mq[i] == 0);
          mq[i] = (mq[i] + MAXS[i]) % (MAXS[i] + 1);
        end
      end
    end
    if (le || do_step) phase = 0;
    else if (mrun) phase = phase + 1;
    if (pe) begin
      mrun = 0; phase = 0;
    end else if (se) begin
      mrun = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    vectors++;
    chk("q15",       {4'd0, q15},        8'(mq[0]));
    chk("running15", {7'd0, running15},  8'(mrun));
    chk("tick15",    {7'd0, tick15},     8'(mtick[0]));
    chk("wrap15",    {7'd0, wrap15},     8'(mwrap[0]));
    chk("q9",        {4'd0, q9},         8'(mq[1]));
    chk("running9",  {7'd0, running9},   8'(mrun));
    chk("tick9",     {7'd0, tick9},      8'(mtick[1]));
    chk("wrap9",     {7'd0, wrap9},      8'(mwrap[1]));
  endtask

  task automatic cyc(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (rst) model_reset(); else model_step();
      @(negedge clk);
      check_all();
    end
  endtask

  initial begin
    bit found;
    model_reset();

    // Reset state
    cyc(3);
    chk("rst_q15", {4'd0, q15}, 8'd0);
    chk("rst_run", {7'd0, running15}, 8'd0);
    rst = 1'b0;
    cyc(2);

    // Load 14 (clamps to 9 on the MAX=9 instance), count up through the wrap
    up = 1'b1; d = 4'd14; load = 1'b1;
    cyc(3);
    load = 1'b0;
    cyc(1);
    start = 1'b1;
    cyc(2);
    start = 1'b0;
    cyc(24);

    // Async reset mid-run once the MAX=15 count reaches 7
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (mq[0] == 7 && mrun) found = 1;
      else cyc(1);
    end
    chk("reach_q7", {7'd0, found}, 8'd1);
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_q15",  {4'd0, q15},       8'd0);
    chk("arst_run",  {7'd0, running15}, 8'd0);
    chk("arst_tick", {7'd0, tick15},    8'd0);
    chk("arst_wrap", {7'd0, wrap15},    8'd0);
    cyc(2);
    rst = 1'b0;
    cyc(4);

    // Down count from 1 through the 0->MAX wrap
    up = 1'b0; d = 4'd1; load = 1'b1;
    cyc(2);
    load = 1'b0; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(30);

    // Load of 12 landing exactly on a step cycle
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (phase == 1) found = 1;
      else cyc(1);
    end
    chk("reach_ph1", {7'd0, found}, 8'd1);
    d = 4'd12; load = 1'b1;
    cyc(1);
    load = 1'b0;
    cyc(2);
    chk("ld_tick9", {7'd0, tick9}, 8'd0);
    chk("ld_wrap9", {7'd0, wrap9}, 8'd0);
    chk("ld_q9",    {4'd0, q9},    8'd9);
    cyc(10);

    // Start and Stop together from IDLE, then Start held for 20 cycles
    stop = 1'b1;
    cyc(3);
    stop = 1'b0;
    cyc(3);
    start = 1'b1; stop = 1'b1;
    cyc(5);
    chk("ss_idle", {7'd0, running15}, 8'd0);
    start = 1'b0; stop = 1'b0;
    cyc(3);
    start = 1'b1;
    cyc(20);
    start = 1'b0;
    cyc(5);

    // Stop part-way through a period, then restart
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (phase == 0 && mrun) found = 1;
      else cyc(1);
    end
    chk("reach_ph0", {7'd0, found}, 8'd1);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    cyc(8);
    up = 1'b1; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(14);

    // Randomised control traffic
    for (int k = 0; k < 400; k++) begin
      start = ($urandom % 14 == 0);
      stop  = ($urandom % 24 == 0);
      load  = ($urandom % 20 == 0);
      if ($urandom % 16 == 0) up = ~up;
      d = 4'($urandom % 16);
      cyc(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hex_step_counter.md
Name: hex_step_counter

Overview:
- Upstream source stage for the binary-to-two-digit-decimal display path: produces the 4-bit binary value (0..15) that the comparator/mux/7-segment decode stage consumes in place of SW[3:0].
- Free-running up/down counter stepped by an internal prescaler tick, started, stopped and loaded from raw push-button/switch-style inputs.
- Raw control inputs are synchronised and edge-detected internally.

Parameters:
- DIV, 50000000, prescaler period in Clock cycles per count step; legal range >= 2.
- MAX, 15, highest count value; legal range 1..15. Wrap-around point for up and down counting.

Ports:
- Clock  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  raw level input; a rising edge requests RUN.
- Stop  input  1  raw level input; a rising edge requests IDLE.
- Load  input  1  raw level input; a rising edge loads D into Q.
- Up  input  1  raw level input; 1 = count up, 0 = count down.
- D  input  4  load value; sampled directly, so it must be held stable while Load is asserted.
- Q  output  4  current count; feeds the decimal display stage.
- Running  output  1  high while the FSM is in RUN.
- Tick  output  1  one-cycle pulse, coincident with each prescaler-driven step of Q.
- Wrap  output  1  one-cycle pulse, coincident with Q wrapping MAX->0 (up) or 0->MAX (down).

Behaviour:
- Reset (async, any time):
  - Q=0, Running=0, Tick=0, Wrap=0.
  - FSM = IDLE, prescaler = 0.
  - All synchroniser and edge flops = 0.
  - Reset mid-count or mid-load abandons the operation with no residual pulse.
- Synchronisation:
  - Start, Stop, Load and Up each pass through a 2-flop synchroniser.
  - Start, Stop and Load add a third delay flop; edge = sync2 & ~sync3.
  - An input first sampled high at edge k produces its action at edge k+2.
  - A held level produces exactly one edge. The next edge requires the input to go low first.
- FSM (2 states):
  - IDLE: Running=0; prescaler held at 0; Q holds. Start edge -> RUN.
  - RUN: Running=1; prescaler increments each cycle. Stop edge -> IDLE, with the prescaler cleared on entry to IDLE.
  - Start and Stop edges in the same cycle: Stop wins (IDLE, or stays IDLE).
  - Start edge while in RUN: ignored, prescaler not disturbed.
  - Stop edge while in IDLE: ignored.
- Prescaler:
  - Width is clog2(DIV); counts 0..DIV-1.
  - In RUN, when prescaler == DIV-1, at the next edge: prescaler <= 0, Q steps, Tick = 1 for one cycle.
  - The first step after entering RUN occurs exactly DIV cycles after Running rises.
- Step arithmetic (4-bit, modulo MAX+1):
  - Up=1: Q <= (Q==MAX) ? 0 : Q+1.
  - Up=0: Q <= (Q==0) ? MAX : Q-1.
  - Wrap = 1 for the same cycle as Tick when the wrap case is taken.
  - Direction uses the synchronised Up value, so a change in Up affects steps taken 2+ cycles after it.
- Load:
  - A Load edge sets Q <= (D > MAX) ? MAX : D, clears the prescaler, and suppresses Tick and Wrap for that cycle.
  - Load has priority over a coincident step.
  - Load works in both IDLE and RUN and does not change FSM state.
  - A Load edge coincident with a Stop edge: both take effect (Q loaded, FSM -> IDLE).
- Outputs Q, Running, Tick and Wrap are all registered; no combinational path from any input to any output.
- The Q range is always 0..MAX; MAX <= 15 guarantees the downstream display stage only ever sees a legal 0..15 input.

Test Plan:
- Reset: DIV=4, MAX=15. Pulse Reset mid-RUN at Q=7 -> Q=0, Running=0, Tick=0, Wrap=0 immediately (async), then IDLE after release.
- Up count and wrap: DIV=4, MAX=15, Up=1, Start edge from Q=14 -> Tick every 4 cycles. Q goes 15, then 0 with Wrap=1 on the 15->0 step only, and Tick=1 on every step.
- Down count with MAX=9: DIV=4, Up=0, load D=1, Start -> Q goes 0, 9 (Wrap=1), 8. Q never exceeds 9.
- Load clamp and priority: MAX=9, RUN, assert Load with D=12 timed to land on a tick cycle -> Q=9, Tick=0, Wrap=0. The prescaler restarts and the next step comes 4 cycles later.
- Start/Stop edges: in IDLE, Start and Stop rise in the same cycle -> stays IDLE, Running=0. Then Start alone -> Running=1 two edges after first sampling. Holding Start high for 20 cycles -> only one transition, and Q is unchanged apart from normal ticks.
- Stop mid-period: DIV=4, RUN, Stop edge when prescaler=2 -> IDLE, Q holds. A later Start -> first step exactly 4 cycles after Running rises.
